// File: rtl/csr_pkg.sv
// CSR addresses, mstatus fields and interrupt cause codes shared by
// the machine-mode CSR file and its timer.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_TIMEH     = 12'hC81;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;

  localparam int CAUSE_MSI        = 3;
  localparam int CAUSE_MTI        = 7;
  localparam int CAUSE_MEI        = 11;
  localparam int CAUSE_LOCAL_BASE = 16;

  localparam logic [31:0] MISA_RESET = 32'h4000_0100;

  function automatic logic [31:0] irq_mask(input int n);
    logic [31:0] m;
    m = '0;
    m[CAUSE_MSI] = 1'b1;
    m[CAUSE_MTI] = 1'b1;
    m[CAUSE_MEI] = 1'b1;
    for (int i = 0; i < n; i++) begin
      m[CAUSE_LOCAL_BASE + i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_mtimer.sv
// Prescaled 64-bit mtime counter with mtimecmp and the MTIP compare.
// Runs entirely in the core clock domain.
module csr_mtimer
  import csr_pkg::*;
#(
  parameter int TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mtimecmp_wdata,
  input  logic        set_mtimecmp_low,
  input  logic        set_mtimecmp_high,
  output logic        mtip,
  output logic [31:0] mtime_low,
  output logic [31:0] mtime_high
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TIMER_DIV - 1);

  logic [PW-1:0] presc;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      mtime <= '0;
    end else if (presc == PMAX) begin
      presc <= '0;
      mtime <= mtime + 64'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
    end else begin
      if (set_mtimecmp_low)
        mtimecmp[31:0] <= mtimecmp_wdata;
      if (set_mtimecmp_high)
        mtimecmp[63:32] <= mtimecmp_wdata;
    end
  end

  assign mtip       = (mtime >= mtimecmp);
  assign mtime_low  = mtime[31:0];
  assign mtime_high = mtime[63:32];

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap/interrupt controller.
// Optional mcycle/minstret counters under `CSR_COUNTERS_EN.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter int          NUM_LOCAL_INT = 4,
  parameter int          TIMER_DIV     = 1,
  parameter logic [31:0] MTVEC_RESET   = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic [11:0]     csr_waddr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_wen,
  input  logic            exception_en,
  input  logic [XLEN-1:0] exception_code,
  input  logic [XLEN-1:0] exp_pc,
  input  logic [XLEN-1:0] exp_val,
  input  logic [XLEN-1:0] int_pc,
  input  logic            mret_en,
  input  logic            ext_int,
  input  logic            soft_int,
  input  logic [(NUM_LOCAL_INT > 0 ? NUM_LOCAL_INT : 1)-1:0] local_int,
`ifdef CSR_COUNTERS_EN
  input  logic            instret_inc,
`endif
  output logic            int_req,
  input  logic            int_ack,
  output logic            trap_jmp_en,
  output logic [XLEN-1:0] trap_jmp_pc,
  input  logic [XLEN-1:0] mtimecmp_wdata,
  input  logic            set_mtimecmp_low,
  input  logic            set_mtimecmp_high,
  output logic [XLEN-1:0] mtime_low,
  output logic [XLEN-1:0] mtime_high
);

  localparam logic [31:0] MIE_MASK = irq_mask(NUM_LOCAL_INT);

  logic [31:0] mstatus;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [31:0] mip;
  logic [31:0] pending;
  logic [31:0] rdata;
  logic [31:0] trap_base;
  logic [4:0]  cause;
  logic        busy;
  logic        mtip;
  logic        take_int;
  logic        ev_exc;
  logic        ev_mret;
  logic        ev_int;
  logic        ev_wr;

  csr_mtimer #(
    .TIMER_DIV(TIMER_DIV)
  ) u_timer (
    .clk              (clk),
    .rst              (rst),
    .mtimecmp_wdata   (mtimecmp_wdata),
    .set_mtimecmp_low (set_mtimecmp_low),
    .set_mtimecmp_high(set_mtimecmp_high),
    .mtip             (mtip),
    .mtime_low        (mtime_low),
    .mtime_high       (mtime_high)
  );

  always_comb begin
    mip = '0;
    mip[CAUSE_MSI] = soft_int;
    mip[CAUSE_MTI] = mtip;
    mip[CAUSE_MEI] = ext_int;
    for (int i = 0; i < NUM_LOCAL_INT; i++) begin
      mip[CAUSE_LOCAL_BASE + i] = local_int[i];
    end
  end

  assign pending = mip & mie;
  assign int_req = mstatus[MSTATUS_MIE] & (|pending) & ~busy;

  // Later assignments win, so the loop order encodes priority.
  always_comb begin
    cause = '0;
    for (int i = 0; i < NUM_LOCAL_INT; i++) begin
      if (pending[CAUSE_LOCAL_BASE + i])
        cause = 5'(CAUSE_LOCAL_BASE + i);
    end
    if (pending[CAUSE_MTI]) cause = 5'(CAUSE_MTI);
    if (pending[CAUSE_MSI]) cause = 5'(CAUSE_MSI);
    if (pending[CAUSE_MEI]) cause = 5'(CAUSE_MEI);
  end

  assign trap_base = {mtvec[31:2], 2'b00};
  assign take_int  = int_ack & int_req;

  assign ev_exc  = exception_en;
  assign ev_mret = mret_en & ~exception_en;
  assign ev_int  = take_int & ~exception_en & ~mret_en;
  assign ev_wr   = csr_wen & ~exception_en & ~mret_en & ~take_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus     <= '0;
      mie         <= '0;
      mtvec       <= MTVEC_RESET;
      mscratch    <= '0;
      mepc        <= '0;
      mcause      <= '0;
      mtval       <= '0;
      busy        <= 1'b0;
      trap_jmp_en <= 1'b0;
      trap_jmp_pc <= '0;
    end else begin
      trap_jmp_en <= 1'b0;
      unique case (1'b1)
        ev_exc: begin
          trap_jmp_en  <= 1'b1;
          trap_jmp_pc  <= trap_base;
          mepc         <= exp_pc;
          mcause       <= exception_code;
          mtval        <= exp_val;
          mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
          mstatus[MSTATUS_MIE]  <= 1'b0;
          mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
        end
        ev_mret: begin
          trap_jmp_en  <= 1'b1;
          trap_jmp_pc  <= mepc;
          mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
          mstatus[MSTATUS_MPIE] <= 1'b1;
          busy         <= 1'b0;
        end
        ev_int: begin
          trap_jmp_en  <= 1'b1;
          trap_jmp_pc  <= mtvec[0]
                        ? trap_base + {25'd0, cause, 2'b00}
                        : trap_base;
          mepc         <= int_pc;
          mcause       <= {1'b1, 26'd0, cause};
          mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
          mstatus[MSTATUS_MIE]  <= 1'b0;
          mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
          busy         <= 1'b1;
        end
        ev_wr: begin
          case (csr_waddr)
            CSR_MSTATUS:  mstatus  <= csr_wdata & MSTATUS_MASK;
            CSR_MIE:      mie      <= csr_wdata & MIE_MASK;
            CSR_MTVEC:    mtvec    <= {csr_wdata[31:2], 1'b0, csr_wdata[0]};
            CSR_MSCRATCH: mscratch <= csr_wdata;
            CSR_MEPC:     mepc     <= csr_wdata;
            CSR_MCAUSE:   mcause   <= csr_wdata;
            CSR_MTVAL:    mtval    <= csr_wdata;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // A CSR write overrides the increment of the same half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle + 64'd1;
      minstret <= minstret + {63'd0, instret_inc};
      if (ev_wr) begin
        case (csr_waddr)
          CSR_MCYCLE:    mcycle[31:0]    <= csr_wdata;
          CSR_MCYCLEH:   mcycle[63:32]   <= csr_wdata;
          CSR_MINSTRET:  minstret[31:0]  <= csr_wdata;
          CSR_MINSTRETH: minstret[63:32] <= csr_wdata;
          default: ;
        endcase
      end
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:   rdata = mstatus;
      CSR_MISA:      rdata = MISA_RESET;
      CSR_MIE:       rdata = mie;
      CSR_MTVEC:     rdata = mtvec;
      CSR_MSCRATCH:  rdata = mscratch;
      CSR_MEPC:      rdata = mepc;
      CSR_MCAUSE:    rdata = mcause;
      CSR_MTVAL:     rdata = mtval;
      CSR_MIP:       rdata = mip;
      CSR_MVENDORID: rdata = '0;
      CSR_MARCHID:   rdata = '0;
      CSR_MIMPID:    rdata = '0;
      CSR_MHARTID:   rdata = '0;
      CSR_TIME:      rdata = mtime_low;
      CSR_TIMEH:     rdata = mtime_high;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH: rdata = minstret[63:32];
`endif
      default:       rdata = '0;
    endcase
  end

  assign csr_rdata = rdata;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: redirects are queued by the
// stimulus and checked by an independent monitor.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] csr_raddr = '0;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr = '0;
  logic [31:0] csr_wdata = '0;
  logic        csr_wen = 1'b0;
  logic        exception_en = 1'b0;
  logic [31:0] exception_code = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_val = '0;
  logic [31:0] int_pc = '0;
  logic        mret_en = 1'b0;
  logic        ext_int = 1'b0;
  logic        soft_int = 1'b0;
  logic [3:0]  local_int = '0;
  logic        int_req;
  logic        int_ack = 1'b0;
  logic        trap_jmp_en;
  logic [31:0] trap_jmp_pc;
  logic [31:0] mtimecmp_wdata = '0;
  logic        set_mtimecmp_low = 1'b0;
  logic        set_mtimecmp_high = 1'b0;
  logic [31:0] mtime_low;
  logic [31:0] mtime_high;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  csr_trap_ctrl #(
    .XLEN         (32),
    .NUM_LOCAL_INT(4),
    .TIMER_DIV    (4),
    .MTVEC_RESET  (32'h0000_0100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .csr_raddr        (csr_raddr),
    .csr_rdata        (csr_rdata),
    .csr_waddr        (csr_waddr),
    .csr_wdata        (csr_wdata),
    .csr_wen          (csr_wen),
    .exception_en     (exception_en),
    .exception_code   (exception_code),
    .exp_pc           (exp_pc),
    .exp_val          (exp_val),
    .int_pc           (int_pc),
    .mret_en          (mret_en),
    .ext_int          (ext_int),
    .soft_int         (soft_int),
    .local_int        (local_int),
`ifdef CSR_COUNTERS_EN
    .instret_inc      (1'b0),
`endif
    .int_req          (int_req),
    .int_ack          (int_ack),
    .trap_jmp_en      (trap_jmp_en),
    .trap_jmp_pc      (trap_jmp_pc),
    .mtimecmp_wdata   (mtimecmp_wdata),
    .set_mtimecmp_low (set_mtimecmp_low),
    .set_mtimecmp_high(set_mtimecmp_high),
    .mtime_low        (mtime_low),
    .mtime_high       (mtime_high)
  );

  always @(negedge clk) begin
    if (rst && trap_jmp_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL trap_unexpected: pc=%h, required no redirect",
                 trap_jmp_pc);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        if (trap_jmp_pc !== e) begin
          n_fail++;
          $display("FAIL trap_pc: got %h required %h", trap_jmp_pc, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] req,
                    input string nm);
    csr_raddr = a;
    #1;
    chk(nm, csr_rdata, req);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_waddr = a;
    csr_wdata = d;
    csr_wen   = 1'b1;
    tick();
    csr_wen   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Reset state and constant registers
    chk("rst_trap_en", {31'd0, trap_jmp_en}, 32'd0);
    chk("rst_trap_pc", trap_jmp_pc, 32'd0);
    chk("rst_int_req", {31'd0, int_req}, 32'd0);
    rd(12'h301, 32'h4000_0100, "misa");
    rd(12'h305, 32'h0000_0100, "mtvec_rst");
    rd(12'h7C0, 32'h0, "unmapped");
    rd(12'h300, 32'h0, "mstatus_rst");
    wr(12'h301, 32'hFFFF_FFFF);
    rd(12'h301, 32'h4000_0100, "misa_ro");

    // Vectored local interrupt, cause 18
    wr(12'h305, 32'h0000_1003);
    rd(12'h305, 32'h0000_1001, "mtvec_bit1");
    wr(12'h304, 32'h0004_0000);
    local_int = 4'b0100;
    wr(12'h300, 32'h0000_0008);
    chk("int_req_local", {31'd0, int_req}, 32'd1);
    int_pc = 32'h0000_0444;
    exp_q.push_back(32'h0000_1048);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    rd(12'h342, 32'h8000_0012, "mcause_local");
    rd(12'h341, 32'h0000_0444, "mepc_local");
    rd(12'h300, 32'h0000_1880, "mstatus_trap");
    chk("int_req_busy", {31'd0, int_req}, 32'd0);

    // mret back to the interrupted PC
    exp_q.push_back(32'h0000_0444);
    mret_en = 1'b1;
    tick();
    mret_en = 1'b0;
    rd(12'h300, 32'h0000_1888, "mstatus_mret");
    chk("int_req_reassert", {31'd0, int_req}, 32'd1);

    // MEI beats MSI; second ack while busy is dropped
    local_int = 4'b0000;
    wr(12'h304, 32'h0000_0808);
    ext_int  = 1'b1;
    soft_int = 1'b1;
    rd(12'h344, 32'h0000_0808, "mip_live");
    chk("int_req_ext", {31'd0, int_req}, 32'd1);
    int_pc = 32'h0000_0888;
    exp_q.push_back(32'h0000_102C);
    int_ack = 1'b1;
    tick();
    rd(12'h342, 32'h8000_000B, "mcause_mei");
    chk("int_req_off", {31'd0, int_req}, 32'd0);
    int_pc = 32'h0000_0999;
    tick();
    int_ack = 1'b0;
    rd(12'h341, 32'h0000_0888, "mepc_ack_ignored");
    exp_q.push_back(32'h0000_0888);
    mret_en = 1'b1;
    tick();
    mret_en  = 1'b0;
    ext_int  = 1'b0;
    soft_int = 1'b0;

    // Exception beats mret and a CSR write in the same cycle
    exp_pc         = 32'h0000_2000;
    exception_code = 32'h0000_0002;
    exp_val        = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0000_1000);
    exception_en = 1'b1;
    mret_en      = 1'b1;
    csr_waddr    = 12'h340;
    csr_wdata    = 32'h0000_0055;
    csr_wen      = 1'b1;
    tick();
    exception_en = 1'b0;
    mret_en      = 1'b0;
    csr_wen      = 1'b0;
    rd(12'h341, 32'h0000_2000, "mepc_exc");
    rd(12'h342, 32'h0000_0002, "mcause_exc");
    rd(12'h343, 32'hDEAD_BEEF, "mtval_exc");
    rd(12'h300, 32'h0000_1880, "mstatus_exc");
    rd(12'h340, 32'h0000_0000, "mscratch_dropped");
    wr(12'h340, 32'h0000_0055);
    rd(12'h340, 32'h0000_0055, "mscratch_wr");
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    rd(12'h342, 32'h0, "mcause_async_rst");
    rd(12'h305, 32'h0000_0100, "mtvec_async_rst");
    chk("trap_pc_async_rst", trap_jmp_pc, 32'd0);
    tick();
    rst = 1'b1;

    // Timer: DIV=4, mtimecmp=3 -> MTIP after 12 clocks
    mtimecmp_wdata    = 32'd0;
    set_mtimecmp_high = 1'b1;
    tick();
    set_mtimecmp_high = 1'b0;
    mtimecmp_wdata    = 32'd3;
    set_mtimecmp_low  = 1'b1;
    tick();
    set_mtimecmp_low  = 1'b0;
    repeat (9) tick();
    rd(12'h344, 32'h0, "mtip_before");
    chk("mtime_11clk", mtime_low, 32'd2);
    tick();
    rd(12'h344, 32'h0000_0080, "mtip_12clk");
    rd(12'hC01, 32'd3, "time_csr");
    chk("int_req_masked", {31'd0, int_req}, 32'd0);

    // 64-bit wrap
    force dut.u_timer.mtime = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_timer.mtime;
    #1;
    chk("mtime_high_max", mtime_high, 32'hFFFF_FFFF);
    rd(12'h344, 32'h0000_0080, "mtip_max");
    repeat (3) tick();
    chk("mtime_low_hold", mtime_low, 32'hFFFF_FFFF);
    tick();
    chk("mtime_low_wrap", mtime_low, 32'd0);
    chk("mtime_high_wrap", mtime_high, 32'd0);
    rd(12'h344, 32'h0, "mtip_wrap");

    repeat (2) tick();
    chk("queue_final", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Parametrised machine-mode CSR file and trap/interrupt controller for the core.
- Supersedes the fixed three-source CSR block:
  - adds N platform-local interrupt lines (mip/mie bits 16+) with fixed priority;
  - adds a two-cycle req/ack interrupt handshake;
  - adds an mtime counter with prescaler in the core clock domain;
  - uses clean single-clock register semantics.
- Sits beside the decode/execute stage; drives the redirect PC to fetch.

Parameters:
- XLEN, 32, data width; must be 32.
- NUM_LOCAL_INT, 4, local interrupt lines, 0..16, mapped to mip/mie bits [16+NUM_LOCAL_INT-1:16].
- TIMER_DIV, 1, mtime increments once every TIMER_DIV clk cycles; must be at least 1.
- MTVEC_RESET, 32'h0, reset value of mtvec.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- csr_raddr  in  12  read address
- csr_rdata  out  XLEN  combinational read data
- csr_waddr  in  12  write address
- csr_wdata  in  XLEN  write data
- csr_wen  in  1  write strobe
- exception_en  in  1  synchronous exception this cycle
- exception_code  in  XLEN  mcause value for the exception
- exp_pc  in  XLEN  faulting PC
- exp_val  in  XLEN  mtval value
- int_pc  in  XLEN  resume PC saved on an interrupt
- mret_en  in  1  mret retiring
- ext_int  in  1  machine external interrupt level (MEIP)
- soft_int  in  1  machine software interrupt level (MSIP)
- local_int  in  max(NUM_LOCAL_INT,1)  local interrupt levels
- int_req  out  1  interrupt pending and enabled
- int_ack  in  1  core ready to take the interrupt
- trap_jmp_en  out  1  one-cycle redirect pulse
- trap_jmp_pc  out  XLEN  redirect target
- mtimecmp_wdata  in  XLEN  mtimecmp write data
- set_mtimecmp_low  in  1  write mtimecmp[31:0]
- set_mtimecmp_high  in  1  write mtimecmp[63:32]
- mtime_low  out  XLEN  mtime[31:0]
- mtime_high  out  XLEN  mtime[63:32]

Behaviour:
- Reset values:
  - mstatus, mie, mscratch, mepc, mcause, mtval = 0; mtvec = MTVEC_RESET; misa = 32'h40000100.
  - mvendorid, marchid, mimpid, mhartid = 0.
  - mtime = 0; mtimecmp = all ones; prescaler = 0.
  - trap_jmp_en = 0; trap_jmp_pc = 0; busy = 0.
- Reads: combinational mux over CSRs 300, 301, 304, 305, 340-344, F11-F14, plus C01/C81 (time/timeh). Unmapped addresses read 0.
- mip is read-only and reflects live levels: bit 11 = ext_int, bit 3 = soft_int, bit 7 = MTIP, bits 16+ = local_int.
- Writes take effect next cycle. misa, mip and the F1x registers ignore writes. mtvec[1] is forced to 0.
- MTIP = (mtime >= mtimecmp), 64-bit unsigned compare on registered values. mtime wraps 2^64-1 to 0. A set_mtimecmp write takes effect next cycle; if low and high are both set in one cycle, both halves are written.
- pending = mip & mie.
- int_req = mstatus.MIE & |pending & ~busy.
- Fixed priority: MEI > MSI > MTI > local_int, highest index first.
- Interrupt handshake: int_ack is sampled while int_req=1. The cause is selected in the ack cycle. In the next cycle:
  - trap_jmp_en=1;
  - mepc=int_pc; mcause={1, cause};
  - MPIE=MIE, MIE=0, MPP=2'b11; busy=1.
- trap_jmp_pc:
  - direct mode (mtvec[0]=0): {mtvec[31:2],2'b00};
  - vectored mode: that base + 4*cause;
  - exceptions always use the base.
- Exception: next cycle trap_jmp_en=1; mepc=exp_pc; mcause=exception_code; mtval=exp_val; MPIE/MIE update as for an interrupt.
- mret: next cycle trap_jmp_en=1; trap_jmp_pc=mepc; MIE=MPIE; MPIE=1; busy=0.
- Simultaneous events, highest priority first: exception > mret > int_ack > csr_wen. The losers are dropped; int_ack is not lost, because int_req stays asserted.
- trap_jmp_en is exactly one cycle wide and returns to 0 in any cycle with no event.
- int_ack with int_req=0 is ignored.
- Asserting rst mid-operation returns every register to its reset value immediately (asynchronous).

Optional Feature:
- Macro CSR_COUNTERS_EN.
- When defined:
  - adds 64-bit mcycle, mapped at B00/B80, incrementing every clk;
  - adds 64-bit minstret, mapped at B02/B82, incremented by a new input instret_inc;
  - both counters are writable per half; a CSR write beats the increment in the same cycle.
- When undefined: addresses B00/B80/B02/B82 read 0, writes are ignored, and the instret_inc port does not exist.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams;
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11);
  - interrupt cause codes 3/7/11/16+;
  - the misa reset constant.
- One sub-module, csr_mtimer: holds the prescaler, mtime, mtimecmp, the MTIP compare and the mtime outputs.

Test Plan:
1. Reset, then read 301 and 305 -> 32'h40000100 and MTVEC_RESET. Read unmapped 7C0 -> 0.
2. mtvec=32'h1001, mie[16+2]=1, MIE=1, local_int=3'b100, int_ack -> next cycle trap_jmp_en=1, trap_jmp_pc=32'h1048, mcause=32'h80000012, MIE=0, MPIE=1.
3. ext_int=1 and soft_int=1 with both enabled -> mcause=32'h8000000B. A second ack before mret is ignored (int_req=0).
4. exception_en and mret_en in the same cycle -> exception wins; mepc=exp_pc; trap_jmp_pc=mtvec base.
5. TIMER_DIV=4, mtimecmp=3 -> MTIP rises after 12 clk. mtime 2^64-1 wraps to 0 and MTIP clears.
6. mret after the step-2 trap -> trap_jmp_pc=int_pc, MIE=1, int_req reasserts if local_int is still high.
